q_proj_byte_mac: RTL and testbench

- Downstream consumer of the Q-projection input byte FIFO.
- Pops the serialized byte stream; the FIFO packs each 32-bit word as 4 data bytes followed by 3 zero pad bytes.
- Multiplies the 4 data bytes of each group by 4 stationary signed weights and accumulates them.
- Presents one dot-product result per 7-byte group on a valid/ready output toward the Q-projection accumulator stage.

---
 rtl/q_proj_byte_mac.sv | 152 +++++++++++++++
 tb/tb_q_proj_byte_mac.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_proj_byte_mac.sv
`default_nettype none
// ============================================================================
//  Module   : q_proj_byte_mac
//  Brief    : Pops 7-byte groups (4 data + 3 pad) from the Q-projection input
//             byte FIFO, multiplies the data bytes by 4 stationary signed
//             weights, accumulates them, and presents one dot-product result
//             per group on a valid/ready interface.
//  Revision : 1.0 - initial release
// ============================================================================
module q_proj_byte_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 4,
    parameter int PAD_LEN    = 3,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_empty,
    output logic                          fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]         fifo_rd_data,
    input  logic                          w_load,
    input  logic [DATA_WIDTH*VEC_LEN-1:0] w_data,
    output logic                          acc_valid,
    input  logic                          acc_ready,
    output logic [ACC_WIDTH-1:0]          acc_data,
    output logic                          busy
);

    localparam int c_group_len = VEC_LEN + PAD_LEN;
    localparam int c_cnt_w     = $clog2(c_group_len + 1);
    localparam int c_idx_w     = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int c_prod_w    = 2 * DATA_WIDTH;

    localparam logic [c_cnt_w-1:0] c_group_cnt = c_cnt_w'(c_group_len);
    localparam logic [c_cnt_w-1:0] c_last_cnt  = c_cnt_w'(c_group_len - 1);
    localparam logic [c_cnt_w-1:0] c_vec_cnt   = c_cnt_w'(VEC_LEN);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,   // issuing pops
        S_DRAIN = 2'd1,   // all pops issued, waiting for in-flight bytes
        S_HOLD  = 2'd2    // result presented, waiting for acceptance
    } state_t;

    state_t                       state_q,     state_d;
    logic [c_cnt_w-1:0]           pop_cnt_q,   pop_cnt_d;
    logic [c_cnt_w-1:0]           rx_cnt_q,    rx_cnt_d;
    logic                         rd_vld_q;
    logic [ACC_WIDTH-1:0]         acc_q,       acc_d;
    logic [ACC_WIDTH-1:0]         acc_data_q,  acc_data_d;
    logic                         acc_valid_q, acc_valid_d;
    logic [DATA_WIDTH*VEC_LEN-1:0] w_q,        w_d;

    logic signed [DATA_WIDTH-1:0] w_arr [VEC_LEN];
    logic [c_idx_w-1:0]           w_idx;
    logic signed [c_prod_w-1:0]   prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic [ACC_WIDTH-1:0]         acc_sum;
    logic                         w_accept;

    // Weight 0 lives in the most significant byte of the packed vector.
    generate
        for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_w_unpack
            assign w_arr[gi] = w_q[DATA_WIDTH*(VEC_LEN-gi)-1 -: DATA_WIDTH];
        end
    endgenerate

    // Pop only while filling and the group still has bytes outstanding;
    // reset blocks the pop combinationally so the FIFO never loses a byte
    // to a request issued in the reset cycle.
    assign fifo_rd_en = !rst && (state_q == S_FILL) && !fifo_empty
                        && (pop_cnt_q < c_group_cnt);

    assign busy = (pop_cnt_q != '0) || rd_vld_q || (state_q != S_FILL);

    // The first pop of a group is excluded as well: busy is still low in that
    // cycle, but the byte it fetches will already be multiplied by w[0].
    assign w_accept = w_load && !busy && !fifo_rd_en;

    assign w_idx    = rx_cnt_q[c_idx_w-1:0];
    assign prod     = $signed(fifo_rd_data) * w_arr[w_idx];
    assign prod_ext = ACC_WIDTH'(prod);
    assign acc_sum  = (rx_cnt_q < c_vec_cnt) ? (acc_q + prod_ext) : acc_q;

    assign acc_valid = acc_valid_q;
    assign acc_data  = acc_data_q;

    // Next-state logic: pop counting, byte consumption, result hand-off.
    always_comb begin
        state_d     = state_q;
        pop_cnt_d   = pop_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        acc_d       = acc_q;
        acc_data_d  = acc_data_q;
        acc_valid_d = acc_valid_q;
        w_d         = w_q;

        if (w_accept) begin
            w_d = w_data;
        end

        if (fifo_rd_en) begin
            pop_cnt_d = pop_cnt_q + 1'b1;
            if (pop_cnt_q == c_last_cnt) begin
                state_d = S_DRAIN;
            end
        end

        if (rd_vld_q) begin
            if (rx_cnt_q == c_last_cnt) begin
                acc_data_d  = acc_sum;
                acc_valid_d = 1'b1;
                acc_d       = '0;
                pop_cnt_d   = '0;
                rx_cnt_d    = '0;
                state_d     = S_HOLD;
            end else begin
                acc_d    = acc_sum;
                rx_cnt_d = rx_cnt_q + 1'b1;
            end
        end

        if ((state_q == S_HOLD) && acc_valid_q && acc_ready) begin
            acc_valid_d = 1'b0;
            state_d     = S_FILL;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            pop_cnt_q   <= '0;
            rx_cnt_q    <= '0;
            rd_vld_q    <= 1'b0;
            acc_q       <= '0;
            acc_data_q  <= '0;
            acc_valid_q <= 1'b0;
            w_q         <= '0;
        end else begin
            state_q     <= state_d;
            pop_cnt_q   <= pop_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            rd_vld_q    <= fifo_rd_en;
            acc_q       <= acc_d;
            acc_data_q  <= acc_data_d;
            acc_valid_q <= acc_valid_d;
            w_q         <= w_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_q_proj_byte_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_q_proj_byte_mac
//  Brief    : Self-checking bench for q_proj_byte_mac. A byte-FIFO model feeds
//             the DUT; a group-level reference model predicts pops, busy,
//             result values and result timing every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_q_proj_byte_mac;

    localparam int DW = 8;
    localparam int VL = 4;
    localparam int PL = 3;
    localparam int AW = 20;
    localparam int GL = VL + PL;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          w_load;
    logic [DW*VL-1:0] w_data;
    logic          acc_valid;
    logic          acc_ready;
    logic [AW-1:0] acc_data;
    logic          busy;

    always #5 clk = ~clk;

    q_proj_byte_mac #(
        .DATA_WIDTH(DW), .VEC_LEN(VL), .PAD_LEN(PL), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .w_load(w_load), .w_data(w_data),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .busy(busy)
    );

    // ---------------- upstream byte FIFO model ----------------
    logic [7:0] mem [0:1023];
    int         wp = 0;            // written by stimulus only
    int         rp = 0;            // written by FIFO process only
    logic       force_empty;

    assign fifo_empty = force_empty || (rp == wp);

    // Registered read port; a reset flushes whatever is still queued.
    always @(posedge clk) begin
        if (rst) begin
            rp <= wp;
        end else if (fifo_rd_en && (rp != wp)) begin
            fifo_rd_data <= mem[rp];
            rp           <= rp + 1;
        end
    end

    // ---------------- reference model + compare ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          m_started = 0;
    int          m_popped = 0;     // bytes of the open group popped so far
    int          m_rp = 0;         // model's own FIFO read index
    int          m_done = 0;       // results accepted downstream
    int          m_first = 0;      // cycle of the group's first pop
    int          m_vcyc = 0;       // cycle the result must become visible
    bit          m_pending = 0;
    logic [31:0] m_w = '0;
    logic [AW-1:0] m_res = '0;
    logic [AW-1:0] m_shown = '0;
    logic [7:0]  grp [0:GL-1];

    // Hand-computed expectations for directed groups (written by stimulus).
    logic [AW-1:0] pin_res [0:63];
    int            pin_lat [0:63];
    int            pin_wr = 0;
    int            pin_rd = 0;
    bit            end_req = 0;
    bit            end_ack = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit               exp_rd;
        bit               exp_busy;
        bit               exp_valid;
        int               s;
        logic signed [7:0] db;
        logic signed [7:0] wb;
        cyc++;
        if (cyc > 40000) begin
            $display("FAIL watchdog: cycle budget exhausted");
            $fatal(1, "watchdog");
        end
        if (rst) begin
            chk("rd_en_during_reset", 32'(fifo_rd_en), 32'd0);
            m_popped  = 0;
            m_pending = 0;
            m_w       = '0;
            m_shown   = '0;
            m_rp      = wp;
            m_started = 1;
        end else if (m_started) begin
            if (m_pending && (cyc == m_vcyc)) begin
                m_shown = m_res;
                if (pin_rd < pin_wr) begin
                    chk("model_pin_result", 32'(m_res), 32'(pin_res[pin_rd]));
                    if (pin_lat[pin_rd] >= 0)
                        chk("latency_first_pop_to_valid", 32'(cyc - m_first), 32'(pin_lat[pin_rd]));
                    pin_rd++;
                end
            end
            exp_rd    = !force_empty && (m_rp != wp) && (m_popped < GL);
            exp_busy  = (m_popped != 0);
            exp_valid = m_pending && (cyc >= m_vcyc);
            chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("acc_valid", 32'(acc_valid), 32'(exp_valid));
            chk("acc_data", 32'(acc_data), 32'(m_shown));

            if (w_load && !exp_busy && !exp_rd) m_w = w_data;

            if (exp_rd) begin
                grp[m_popped] = mem[m_rp];
                m_rp++;
                if (m_popped == 0) m_first = cyc;
                m_popped++;
                if (m_popped == GL) begin
                    s = 0;
                    for (int i = 0; i < VL; i++) begin
                        db = grp[i];
                        wb = m_w[8*(VL-i)-1 -: 8];
                        s += int'(db) * int'(wb);
                    end
                    m_res     = s[AW-1:0];
                    m_pending = 1;
                    m_vcyc    = cyc + 2;
                end
            end else if (exp_valid && acc_ready) begin
                m_pending = 0;
                m_popped  = 0;
                m_done++;
            end

            if (end_req && !end_ack) begin
                chk("pinned_groups_seen", 32'(pin_rd), 32'(pin_wr));
                chk("no_result_left_pending", 32'(m_pending), 32'd0);
                end_ack = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    int ng = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp++;
    endtask

    task automatic push_grp(input logic [55:0] g);
        for (int i = 0; i < GL; i++) push(g[55-8*i -: 8]);
    endtask

    task automatic pin(input logic [AW-1:0] res, input int lat);
        pin_res[pin_wr] = res;
        pin_lat[pin_wr] = lat;
        pin_wr++;
    endtask

    task automatic load_w(input logic [31:0] v);
        w_data = v;
        w_load = 1'b1;
        step();
        w_load = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int k = 0; k < 600 && m_done < n; k++) step();
    endtask

    task automatic wait_pop(input int n);
        for (int k = 0; k < 200 && m_popped != n; k++) step();
    endtask

    initial begin
        rst = 1'b1; w_load = 1'b0; w_data = '0; acc_ready = 1'b1; force_empty = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Basic dot product: 16 + 64 - 48 - 128 = -96
        load_w(32'h0102FF80);
        pin(20'hFFFA0, 8);
        push_grp(56'h10203001000000);
        ng++; wait_done(ng);

        // Extremes: 4 * (-128 * -128) = 65536; non-zero pads ignored
        load_w(32'h80808080);
        pin(20'h10000, 8); push_grp(56'h80808080000000);
        pin(20'h10000, 8); push_grp(56'h808080807F7F7F);
        ng += 2; wait_done(ng);

        // Empty gaps: 2 cycles after byte 2, 3 cycles after byte 5 -> +5 cycles
        load_w(32'h0102FF80);
        pin(20'hFFFA0, 13);
        push_grp(56'h10203001000000);
        ng++;
        wait_pop(2); force_empty = 1'b1; repeat (2) step(); force_empty = 1'b0;
        wait_pop(5); force_empty = 1'b1; repeat (3) step(); force_empty = 1'b0;
        wait_done(ng);

        // Backpressure then back-to-back group: 1+2-1-128 = -126, then 127
        acc_ready = 1'b0;
        pin(20'hFFF82, 8); push_grp(56'h01010101000000);
        pin(20'd127, 8);   push_grp(56'h7F000000000000);
        ng += 2;
        for (int k = 0; k < 40 && !acc_valid; k++) step();
        repeat (5) step();
        acc_ready = 1'b1;
        wait_done(ng);

        // Weight protection: mid-group load ignored for this and next group
        pin(20'd2, 8);     push_grp(56'h02000000AABBCC);
        pin(20'hFFF80, 8); push_grp(56'h00000001000000);
        ng += 2;
        wait_pop(3);
        w_data = 32'h7F7F7F7F; w_load = 1'b1; step(); w_load = 1'b0;
        wait_done(ng);
        load_w(32'h7F7F7F7F);
        pin(20'd508, 8); push_grp(56'h01010101000000);
        ng++; wait_done(ng);

        // Reset after pop 4: group dropped, weights cleared
        push_grp(56'h09090909090909);
        wait_pop(4);
        rst = 1'b1; step(); rst = 1'b0;
        pin(20'd0, 8); push_grp(56'h05060708000000);
        ng++; wait_done(ng);
        load_w(32'h01010101);
        pin(20'd10, 8); push_grp(56'h01020304000000);
        ng++; wait_done(ng);

        // Randomized traffic: data, gaps, backpressure and weight loads
        for (int g = 0; g < 30; g++)
            for (int i = 0; i < GL; i++) push(8'($urandom_range(0, 255)));
        ng += 30;
        for (int k = 0; k < 3000 && m_done < ng; k++) begin
            acc_ready   = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 4) == 0);
            w_load      = ($urandom_range(0, 7) == 0);
            w_data      = $urandom;
            step();
        end
        acc_ready = 1'b1; force_empty = 1'b0; w_load = 1'b0;
        wait_done(ng);

        end_req = 1;
        for (int k = 0; k < 10 && !end_ack; k++) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
